// File: rtl/dmem_arbiter_pkg.sv
// Shared defines and package for the data-memory arbiter: FSM encodings and default widths.
// Define DMEM_ATOMIC_LOCK_EN at build time to hold the bus across atomic read/write pairs.
`ifndef DMEM_ARBITER_DEFINES
`define DMEM_ARBITER_DEFINES
`define DMEM_IDLE 1'b0
`define DMEM_RESP 1'b1
`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef DATA_ADDR_W
`define DATA_ADDR_W 10
`endif
`endif

package dmem_arbiter_pkg;
  localparam logic [0:0] ST_IDLE = `DMEM_IDLE;
  localparam logic [0:0] ST_RESP = `DMEM_RESP;
endpackage

// File: rtl/dmem_ram.sv
// Single-port data RAM: synchronous read, write enable, read-before-write. Contents are not reset.
module dmem_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin data-memory responder for NUM_CORES cores, two cycles per access (grant, response).
// Optional bus lock across atomic read/write pairs when DMEM_ATOMIC_LOCK_EN is defined.
`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef DATA_ADDR_W
`define DATA_ADDR_W 10
`endif

module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int DATA_W    = `DATA_W,
  parameter int ADDR_W    = `DATA_ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          mem_read,
  input  logic [NUM_CORES-1:0]          mem_write,
  input  logic [NUM_CORES-1:0]          mem_atomic,
  input  logic [NUM_CORES*ADDR_W-1:0]   mem_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   mem_data_w,
  output logic [NUM_CORES*DATA_W-1:0]   mem_data_r,
  output logic [NUM_CORES-1:0]          mem_wait
);
  localparam int OWN_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [0:0]           r_state;
  logic [OWN_W-1:0]     r_owner;
  logic [OWN_W-1:0]     r_rr;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic                 r_wr;

  logic [NUM_CORES-1:0] w_req;
  logic [NUM_CORES-1:0] w_elig;
  logic                 w_any;
  logic [OWN_W-1:0]     w_pick;
  logic [ADDR_W-1:0]    w_pick_addr;
  logic [DATA_W-1:0]    w_pick_wdata;
  logic [ADDR_W-1:0]    w_ram_addr;
  logic [DATA_W-1:0]    w_rdata;

  // First eligible core at or after ptr, wrapping around.
  function automatic logic [OWN_W-1:0] rr_pick(input logic [NUM_CORES-1:0] elig,
                                                input logic [OWN_W-1:0] ptr);
    logic [2*NUM_CORES-1:0] dbl;
    logic [NUM_CORES-1:0]   rot;
    logic [OWN_W-1:0]       pick;
    int                     sum;
    dbl  = {elig, elig} >> ptr;
    rot  = dbl[NUM_CORES-1:0];
    pick = ptr;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = int'(ptr) + k;
        if (sum >= NUM_CORES) sum = sum - NUM_CORES;
        pick = OWN_W'(sum);
      end
    end
    return pick;
  endfunction

  assign w_req = mem_read | mem_write;

`ifdef DMEM_ATOMIC_LOCK_EN
  logic             r_rd;
  logic             r_atomic;
  logic             r_lock_valid;
  logic [OWN_W-1:0] r_lock_owner;

  assign w_elig = r_lock_valid ? (w_req & (NUM_CORES'(1) << r_lock_owner)) : w_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd     <= 1'b0;
      r_atomic <= 1'b0;
    end else if (r_state == ST_IDLE && w_any) begin
      r_rd     <= mem_read[w_pick];
      r_atomic <= mem_atomic[w_pick];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock_valid <= 1'b0;
      r_lock_owner <= '0;
    end else if (r_state == ST_RESP) begin
      if (r_atomic && r_rd && !r_wr) begin
        r_lock_valid <= 1'b1;
        r_lock_owner <= r_owner;
      end else if (r_atomic && r_wr && r_lock_valid && (r_lock_owner == r_owner)) begin
        r_lock_valid <= 1'b0;
      end
    end
  end
`else
  logic w_unused_atomic;
  assign w_unused_atomic = ^mem_atomic;
  assign w_elig = w_req;
`endif

  assign w_any  = |w_elig;
  assign w_pick = rr_pick(w_elig, r_rr);

  always_comb begin
    w_pick_addr  = '0;
    w_pick_wdata = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_pick == OWN_W'(i)) begin
        w_pick_addr  = mem_addr[i*ADDR_W +: ADDR_W];
        w_pick_wdata = mem_data_w[i*DATA_W +: DATA_W];
      end
    end
  end

  // The RAM sees the winner's address during the grant cycle so data is ready in RESP.
  assign w_ram_addr = (r_state == ST_IDLE) ? w_pick_addr : r_addr;

  dmem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    ((r_state == ST_RESP) && r_wr),
    .i_addr  (w_ram_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_rr    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_owner <= w_pick;
            r_addr  <= w_pick_addr;
            r_wdata <= w_pick_wdata;
            r_wr    <= mem_write[w_pick];
            r_state <= ST_RESP;
          end
        end
        default: begin
          r_rr    <= (r_owner == OWN_W'(NUM_CORES - 1)) ? '0 : r_owner + 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mem_wait   = w_req;
    mem_data_r = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (r_state == ST_RESP && r_owner == OWN_W'(i)) begin
        mem_wait[i]                    = 1'b0;
        mem_data_r[i*DATA_W +: DATA_W] = w_rdata;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_dmem_arbiter;
  localparam int N     = 3;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    mem_read, mem_write, mem_atomic, mem_wait;
  logic [N*AW-1:0] mem_addr;
  logic [N*DW-1:0] mem_data_w, mem_data_r;

  dmem_arbiter #(.NUM_CORES(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_atomic (mem_atomic),
    .mem_addr   (mem_addr),
    .mem_data_w (mem_data_w),
    .mem_data_r (mem_data_r),
    .mem_wait   (mem_wait)
  );

  // Per-core request stimulus
  bit            s_rd [N];
  bit            s_wr [N];
  bit            s_at [N];
  logic [AW-1:0] s_addr [N];
  logic [DW-1:0] s_wd [N];

  // Reference model: memory image, who is being answered this cycle, pointer, lock
  logic [DW-1:0] m_mem [DEPTH];
  int            m_serving;
  int            m_rr;
  bit            m_lock;
  int            m_lock_owner;

  int            n_err = 0;
  int            n_chk = 0;
  int            wait_cnt [N];
  int            last_wait [N];
  logic [DW-1:0] last_data [N];
  int            served_q [$];
  int            mode;
  bit            chk_bound;
  int            just_served;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit req(input int i);
    return s_rd[i] | s_wr[i];
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      mem_read[i]              = s_rd[i];
      mem_write[i]             = s_wr[i];
      mem_atomic[i]            = s_at[i];
      mem_addr[i*AW +: AW]     = s_addr[i];
      mem_data_w[i*DW +: DW]   = s_wd[i];
    end
  endtask

  task automatic set_req(input int i, input bit rd, input bit wr, input bit at,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    s_rd[i] = rd; s_wr[i] = wr; s_at[i] = at; s_addr[i] = a; s_wd[i] = d;
    drive();
  endtask

  task automatic rand_req(input int i);
    int t;
    if ($urandom_range(0, 9) < 6) begin
      t = $urandom_range(0, 2);
      set_req(i, t != 1, t != 0, $urandom_range(0, 3) == 0, AW'($urandom), $urandom);
    end else begin
      set_req(i, 0, 0, 0, s_addr[i], s_wd[i]);
    end
  endtask

  task automatic model_reset();
    m_serving    = -1;
    m_rr         = 0;
    m_lock       = 0;
    m_lock_owner = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  // End-of-cycle model: an answered access commits; otherwise a fresh grant is chosen.
  task automatic model_update();
    int s, c;
    if (m_serving >= 0) begin
      s = m_serving;
      if (s_wr[s]) m_mem[s_addr[s]] = s_wd[s];
      m_rr = (s + 1) % N;
`ifdef DMEM_ATOMIC_LOCK_EN
      if (s_at[s] && s_rd[s] && !s_wr[s]) begin
        m_lock = 1; m_lock_owner = s;
      end else if (s_at[s] && s_wr[s] && m_lock && m_lock_owner == s) begin
        m_lock = 0;
      end
`endif
      m_serving = -1;
    end else begin
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (m_serving < 0 && req(c) && (!m_lock || c == m_lock_owner)) m_serving = c;
      end
    end
  endtask

  task automatic step();
    logic          exp_w;
    logic [DW-1:0] exp_d;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      exp_w = req(i) && (m_serving != i);
      exp_d = (m_serving == i) ? m_mem[s_addr[i]] : '0;
      chk($sformatf("wait%0d", i), mem_wait[i], exp_w);
      chk($sformatf("rdata%0d", i), mem_data_r[i*DW +: DW], exp_d);
      if (req(i) && !mem_wait[i]) begin
        served_q.push_back(i);
        last_data[i] = mem_data_r[i*DW +: DW];
        last_wait[i] = wait_cnt[i];
`ifndef DMEM_ATOMIC_LOCK_EN
        if (chk_bound) chk($sformatf("wait_bound%0d", i), wait_cnt[i] <= 2 * N, 1);
`endif
        wait_cnt[i] = 0;
      end else if (mem_wait[i]) begin
        wait_cnt[i]++;
      end
    end
    just_served = m_serving;
    model_update();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (just_served == i) begin
        if (mode == 0) set_req(i, 0, 0, 0, s_addr[i], s_wd[i]);
        else if (mode == 2) rand_req(i);
      end else if (mode == 2 && !req(i)) begin
        rand_req(i);
      end
    end
  endtask

  task automatic run_idle(input int bound);
    int  k;
    bit  busy;
    k = 0;
    busy = 1;
    while (busy && k < bound) begin
      busy = 0;
      for (int i = 0; i < N; i++) if (req(i)) busy = 1;
      if (busy) begin
        step();
        k++;
      end
    end
    busy = 0;
    for (int i = 0; i < N; i++) if (req(i)) busy = 1;
    if (busy) chk("timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    mode = 0;
    chk_bound = 0;
    for (int i = 0; i < N; i++) set_req(i, 0, 0, 0, '0, '0);
    for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", mem_data_r == '0, 1);
    chk("rst_wait", mem_wait, '0);
    rst = 1'b0;

    for (int a = 0; a < DEPTH; a++) begin
      set_req(0, 0, 1, 0, AW'(a), '0);
      run_idle(10);
    end

    // Single core write then read
    do_reset();
    set_req(0, 0, 1, 0, 4'd5, 32'hDEADBEEF);
    run_idle(10);
    chk("t1_wr_wait", last_wait[0], 1);
    set_req(0, 1, 0, 0, 4'd5, '0);
    run_idle(10);
    chk("t1_rd_wait", last_wait[0], 1);
    chk("t1_rd_data", last_data[0], 32'hDEADBEEF);

    // Two simultaneous readers after reset
    do_reset();
    served_q.delete();
    set_req(0, 1, 0, 0, 4'd1, '0);
    set_req(1, 1, 0, 0, 4'd5, '0);
    run_idle(20);
    chk("t2_order0", served_q[0], 0);
    chk("t2_order1", served_q[1], 1);
    chk("t2_wait0", last_wait[0], 1);
    chk("t2_wait1", last_wait[1], 3);
    chk("t2_data1", last_data[1], 32'hDEADBEEF);
    served_q.delete();
    set_req(0, 1, 0, 0, 4'd1, '0);
    set_req(1, 1, 0, 0, 4'd1, '0);
    run_idle(20);
    chk("t2_next_first", served_q[0], 0);

    // Swap: read+write returns old value
    set_req(0, 1, 1, 0, 4'd7, 32'h1);
    run_idle(10);
    chk("t3_old", last_data[0], 32'h0);
    set_req(0, 1, 0, 0, 4'd7, '0);
    run_idle(10);
    chk("t3_new", last_data[0], 32'h1);

`ifdef DMEM_ATOMIC_LOCK_EN
    do_reset();
    served_q.delete();
    set_req(1, 1, 0, 1, 4'd3, '0);
    run_idle(10);
    set_req(0, 1, 0, 0, 4'd4, '0);
    repeat (6) step();
    chk("lk_blocked", served_q.size(), 1);
    set_req(1, 0, 1, 1, 4'd3, 32'h9);
    run_idle(20);
    chk("lk_count", served_q.size(), 3);
    chk("lk_wr_first", served_q[1], 1);
    chk("lk_then0", served_q[2], 0);
`endif

    // Reset during the response cycle of a write
    do_reset();
    set_req(0, 0, 1, 0, 4'd2, 32'hAA);
    run_idle(10);
    set_req(0, 0, 1, 0, 4'd2, 32'h55);
    step();
    @(negedge clk);
    chk("rst_resp_wait", mem_wait[0], 0);
    rst = 1'b1;
    #1;
    chk("rst_mid_data", mem_data_r == '0, 1);
    chk("rst_mid_wait", mem_wait[0], 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    set_req(0, 1, 0, 0, 4'd2, '0);
    run_idle(10);
    chk("rst_ram_kept", last_data[0], 32'hAA);
    chk("rst_idle_wait", last_wait[0], 1);

    // Continuous requests from all cores
    do_reset();
    served_q.delete();
    mode = 1;
    chk_bound = 1;
    set_req(0, 1, 0, 0, 4'd0, '0);
    set_req(1, 1, 0, 0, 4'd1, '0);
    set_req(2, 1, 0, 0, 4'd2, '0);
    repeat (12) step();
    for (int k = 0; k < 6; k++) chk($sformatf("cont_order%0d", k), served_q[k], k % N);
    mode = 0;
    run_idle(30);

    // Random traffic
    mode = 2;
    repeat (3000) step();
    mode = 0;
    run_idle(200);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
